// File: rtl/framebuffer_writer_if.sv
// Renderer pixel stream into the frame buffer writer: AXI-style valid/ready
// handshake carrying RGB888 plus the scan position of the pixel.
interface framebuffer_writer_if;
  logic [23:0] pixel_tdata;
  logic        pixel_tvalid;
  logic        pixel_tready;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;

  modport master (
    output pixel_tdata,
    output pixel_tvalid,
    output hcount_in,
    output vcount_in,
    input  pixel_tready
  );

  modport slave (
    input  pixel_tdata,
    input  pixel_tvalid,
    input  hcount_in,
    input  vcount_in,
    output pixel_tready
  );
endinterface

// File: rtl/framebuffer_writer.sv
// Frame buffer port-A writer: maps tagged RGB888 pixels to RGB444 BRAM writes (1 cycle latency)
// and fills the buffer with a background colour on request; tready is low for the whole fill.
module framebuffer_writer #(
  parameter int START_X       = 390,
  parameter int START_Y       = 390,
  parameter int END_X         = 634,
  parameter int END_Y         = 765,
  parameter int REGION_DIVIDE = 530,
  parameter int CYL_SHIFT     = 2,
  parameter int ADDR_WIDTH    = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  framebuffer_writer_if.slave   pix,
  input  logic                  clear_in,
  input  logic [11:0]           clear_color_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [11:0]           ram_data_out,
  output logic                  ram_we_out,
  output logic                  frame_done_out,
  output logic                  busy_out,
  output logic [15:0]           drop_count_out
);

  localparam int WIDTH  = END_X - START_X;
  localparam int HEIGHT = END_Y - START_Y;
  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {STREAM, CLEAR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [11:0]           clear_color;
  logic                  accept;
  logic                  in_cyl;
  logic                  pix_valid;
  logic                  pix_last;
  logic [19:0]           col;
  logic [19:0]           row;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [11:0]           pix_data;

  assign pix.pixel_tready = (state == STREAM) && !rst_in;
  assign accept           = pix.pixel_tvalid && pix.pixel_tready;
  assign busy_out         = (state == CLEAR);

  // Rows above REGION_DIVIDE are drawn by the cylinder pass, which lands CYL_SHIFT columns late.
  assign in_cyl    = pix.vcount_in < 10'(REGION_DIVIDE);
  assign pix_valid = (pix.hcount_in >= 11'(START_X)) && (pix.hcount_in < 11'(END_X)) &&
                     (pix.vcount_in >= 10'(START_Y)) && (pix.vcount_in < 10'(END_Y)) &&
                     (!in_cyl || (pix.hcount_in >= 11'(START_X + CYL_SHIFT)));
  assign pix_last  = (pix.hcount_in == 11'(END_X - 1)) && (pix.vcount_in == 10'(END_Y - 1));

  assign col      = 20'(pix.hcount_in) - 20'(START_X) - (in_cyl ? 20'(CYL_SHIFT) : 20'd0);
  assign row      = 20'(pix.vcount_in) - 20'(START_Y);
  assign pix_addr = ADDR_WIDTH'(col + row * 20'(WIDTH));
  assign pix_data = {pix.pixel_tdata[23:20], pix.pixel_tdata[15:12], pix.pixel_tdata[7:4]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= STREAM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STREAM:  if (clear_in) state_nxt = CLEAR;
      CLEAR:   if (clear_addr == LAST_ADDR) state_nxt = STREAM;
      default: state_nxt = STREAM;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ram_addr_out   <= '0;
      ram_data_out   <= '0;
      ram_we_out     <= 1'b0;
      frame_done_out <= 1'b0;
      drop_count_out <= '0;
      clear_addr     <= '0;
      clear_color    <= '0;
    end else begin
      ram_we_out     <= 1'b0;
      frame_done_out <= 1'b0;
      if (state == CLEAR) begin
        ram_we_out   <= 1'b1;
        ram_addr_out <= clear_addr;
        ram_data_out <= clear_color;
        clear_addr   <= clear_addr + ADDR_WIDTH'(1);
      end else begin
        if (accept) begin
          if (pix_valid) begin
            ram_we_out     <= 1'b1;
            ram_addr_out   <= pix_addr;
            ram_data_out   <= pix_data;
            frame_done_out <= pix_last;
          end else if (drop_count_out != 16'hFFFF) begin
            drop_count_out <= drop_count_out + 16'd1;
          end
        end
        // A pixel accepted alongside the request is still written above; the fill starts next cycle.
        if (clear_in) begin
          clear_color <= clear_color_in;
          clear_addr  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: vector table through a scoreboard, plus clear, reset-abort
// and drop-saturation sequences; a small-geometry instance exercises a complete fill.
module tb_framebuffer_writer;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [23:0] d;
    logic        we;
    logic [16:0] addr;
    logic [11:0] data;
    logic        done;
  } vec_t;

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [11:0] data;
    logic        done;
    logic [15:0] drop;
  } exp_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Full-size instance
  logic        rst_in;
  logic        clear_in;
  logic [11:0] clear_color_in;
  logic [16:0] ram_addr_out;
  logic [11:0] ram_data_out;
  logic        ram_we_out;
  logic        frame_done_out;
  logic        busy_out;
  logic [15:0] drop_count_out;
  framebuffer_writer_if pix_if();

  framebuffer_writer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pix            (pix_if),
    .clear_in       (clear_in),
    .clear_color_in (clear_color_in),
    .ram_addr_out   (ram_addr_out),
    .ram_data_out   (ram_data_out),
    .ram_we_out     (ram_we_out),
    .frame_done_out (frame_done_out),
    .busy_out       (busy_out),
    .drop_count_out (drop_count_out)
  );

  // Small instance: 6x4 window, DEPTH = 24, so a whole fill runs quickly
  logic        rst_s;
  logic        clear_s;
  logic [11:0] color_s;
  logic [4:0]  addr_s;
  logic [11:0] data_s;
  logic        we_s;
  logic        done_s;
  logic        busy_s;
  logic [15:0] drop_s;
  framebuffer_writer_if pix_s_if();

  framebuffer_writer #(
    .START_X(10), .START_Y(20), .END_X(16), .END_Y(24),
    .REGION_DIVIDE(22), .CYL_SHIFT(2), .ADDR_WIDTH(5)
  ) dut_s (
    .clk_in         (clk_in),
    .rst_in         (rst_s),
    .pix            (pix_s_if),
    .clear_in       (clear_s),
    .clear_color_in (color_s),
    .ram_addr_out   (addr_s),
    .ram_data_out   (data_s),
    .ram_we_out     (we_s),
    .frame_done_out (done_s),
    .busy_out       (busy_s),
    .drop_count_out (drop_s)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_drop = '0;
  exp_t        sb_q[$];
  vec_t        vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_px(input int idx, input vec_t vv);
    exp_t e;
    @(negedge clk_in);
    pix_if.hcount_in    = vv.h;
    pix_if.vcount_in    = vv.v;
    pix_if.pixel_tdata  = vv.d;
    pix_if.pixel_tvalid = 1'b1;
    if (!vv.we && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    e.we   = vv.we;
    e.addr = vv.addr;
    e.data = vv.data;
    e.done = vv.done;
    e.drop = exp_drop;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    e = sb_q.pop_front();
    check($sformatf("we[%0d]", idx), ram_we_out, e.we);
    check($sformatf("frame_done[%0d]", idx), frame_done_out, e.done);
    check($sformatf("drop[%0d]", idx), drop_count_out, e.drop);
    if (e.we) begin
      check($sformatf("addr[%0d]", idx), ram_addr_out, e.addr);
      check($sformatf("data[%0d]", idx), ram_data_out, e.data);
    end
  endtask

  initial begin
    int   seq_err;
    int   busy_cnt;
    int   done_seen;
    int   next_addr;
    logic reached;
    vec_t vp;

    vecs[0]  = '{11'd390, 10'd600, 24'hF0A05A, 1'b1, 17'd51240, 12'hFA5, 1'b0};
    vecs[1]  = '{11'd392, 10'd390, 24'h123456, 1'b1, 17'd0,     12'h135, 1'b0};
    vecs[2]  = '{11'd390, 10'd400, 24'hFFFFFF, 1'b0, 17'd0,     12'h000, 1'b0};
    vecs[3]  = '{11'd100, 10'd100, 24'hFFFFFF, 1'b0, 17'd0,     12'h000, 1'b0};
    vecs[4]  = '{11'd633, 10'd764, 24'hFFFFFF, 1'b1, 17'd91499, 12'hFFF, 1'b1};
    vecs[5]  = '{11'd633, 10'd763, 24'h00FF00, 1'b1, 17'd91255, 12'h0F0, 1'b0};
    vecs[6]  = '{11'd391, 10'd530, 24'hABCDEF, 1'b1, 17'd34161, 12'hACE, 1'b0};
    vecs[7]  = '{11'd391, 10'd529, 24'hABCDEF, 1'b0, 17'd0,     12'h000, 1'b0};
    vecs[8]  = '{11'd634, 10'd600, 24'h111111, 1'b0, 17'd0,     12'h000, 1'b0};
    vecs[9]  = '{11'd389, 10'd600, 24'h111111, 1'b0, 17'd0,     12'h000, 1'b0};
    vecs[10] = '{11'd500, 10'd765, 24'h111111, 1'b0, 17'd0,     12'h000, 1'b0};
    vecs[11] = '{11'd500, 10'd389, 24'h111111, 1'b0, 17'd0,     12'h000, 1'b0};
    vecs[12] = '{11'd633, 10'd390, 24'h0000FF, 1'b1, 17'd241,   12'h00F, 1'b0};
    vecs[13] = '{11'd392, 10'd529, 24'h000000, 1'b1, 17'd33916, 12'h000, 1'b0};
    vecs[14] = '{11'd633, 10'd764, 24'hA5A5A5, 1'b1, 17'd91499, 12'hAAA, 1'b1};
    vecs[15] = '{11'd390, 10'd764, 24'h102030, 1'b1, 17'd91256, 12'h123, 1'b0};

    rst_in = 1'b1;  rst_s = 1'b1;
    clear_in = 1'b0; clear_color_in = '0;
    clear_s = 1'b0;  color_s = '0;
    pix_if.pixel_tvalid = 1'b0; pix_if.pixel_tdata = '0;
    pix_if.hcount_in = '0;      pix_if.vcount_in = '0;
    pix_s_if.pixel_tvalid = 1'b0; pix_s_if.pixel_tdata = '0;
    pix_s_if.hcount_in = '0;      pix_s_if.vcount_in = '0;

    #12;
    check("rst tready", pix_if.pixel_tready, 1'b0);
    check("rst we", ram_we_out, 1'b0);
    check("rst addr", ram_addr_out, 17'd0);
    check("rst data", ram_data_out, 12'd0);
    check("rst frame_done", frame_done_out, 1'b0);
    check("rst busy", busy_out, 1'b0);
    check("rst drop", drop_count_out, 16'd0);

    @(negedge clk_in);
    rst_in = 1'b0; rst_s = 1'b0;
    #1;
    check("post-rst tready", pix_if.pixel_tready, 1'b1);

    // Back-to-back pixels with tvalid held high across the table
    for (int i = 0; i < 16; i++) send_px(i, vecs[i]);

    @(negedge clk_in);
    pix_if.pixel_tvalid = 1'b0;
    @(posedge clk_in);
    #1;
    check("idle we", ram_we_out, 1'b0);
    check("idle frame_done", frame_done_out, 1'b0);
    check("idle addr hold", ram_addr_out, 17'd91256);

    // Pixel accepted together with the clear request
    @(negedge clk_in);
    pix_if.hcount_in = 11'd500; pix_if.vcount_in = 10'd700;
    pix_if.pixel_tdata = 24'h00FF00; pix_if.pixel_tvalid = 1'b1;
    clear_in = 1'b1; clear_color_in = 12'h123;
    @(posedge clk_in);
    #1;
    check("clr px we", ram_we_out, 1'b1);
    check("clr px addr", ram_addr_out, 17'd75750);
    check("clr px data", ram_data_out, 12'h0F0);
    check("clr tready", pix_if.pixel_tready, 1'b0);
    check("clr busy", busy_out, 1'b1);

    seq_err = 0;
    reached = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk_in);
      clear_in = (k == 500);
      clear_color_in = 12'hABC;
      pix_if.pixel_tvalid = (k == 500);
      @(posedge clk_in);
      #1;
      if (!ram_we_out || ram_addr_out != 17'(k) || ram_data_out != 12'h123 || frame_done_out)
        seq_err++;
      if (ram_we_out && ram_addr_out == 17'd1000) begin
        reached = 1'b1;
        break;
      end
    end
    clear_in = 1'b0;
    pix_if.pixel_tvalid = 1'b0;
    check("clr reached 1000", reached, 1'b1);
    check("clr sequence errors", seq_err, 0);
    check("clr drop unchanged", drop_count_out, exp_drop);

    // Asynchronous reset mid-clear
    #2;
    rst_in = 1'b1;
    #1;
    check("abort we", ram_we_out, 1'b0);
    check("abort addr", ram_addr_out, 17'd0);
    check("abort data", ram_data_out, 12'd0);
    check("abort busy", busy_out, 1'b0);
    check("abort tready", pix_if.pixel_tready, 1'b0);
    check("abort drop", drop_count_out, 16'd0);
    exp_drop = '0;

    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("re-arm tready", pix_if.pixel_tready, 1'b1);
    vp = '{11'd390, 10'd600, 24'h123456, 1'b1, 17'd51240, 12'h135, 1'b0};
    send_px(100, vp);

    // Drop counter saturation
    @(negedge clk_in);
    pix_if.hcount_in = 11'd0; pix_if.vcount_in = 10'd0; pix_if.pixel_tvalid = 1'b1;
    repeat (65534) @(posedge clk_in);
    #1;
    check("drop 0xFFFE", drop_count_out, 16'hFFFE);
    repeat (6) @(posedge clk_in);
    #1;
    check("drop saturated", drop_count_out, 16'hFFFF);
    check("drop no write", ram_we_out, 1'b0);
    pix_if.pixel_tvalid = 1'b0;

    // Complete fill on the small instance
    @(negedge clk_in);
    clear_s = 1'b1; color_s = 12'h123;
    @(posedge clk_in);
    #1;
    check("s tready drop", pix_s_if.pixel_tready, 1'b0);
    check("s busy", busy_s, 1'b1);
    busy_cnt = 1;
    done_seen = 0;
    next_addr = 0;
    seq_err = 0;
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_in);
      clear_s = (k == 10);
      color_s = 12'hEEE;
      @(posedge clk_in);
      #1;
      if (busy_s) busy_cnt++;
      if (done_s) done_seen++;
      if (we_s) begin
        if (addr_s != 5'(next_addr) || data_s != 12'h123) seq_err++;
        next_addr++;
      end
      if (!busy_s && !we_s) begin
        reached = 1'b1;
        break;
      end
    end
    clear_s = 1'b0;
    check("s fill finished", reached, 1'b1);
    check("s writes", next_addr, 24);
    check("s sequence errors", seq_err, 0);
    check("s busy cycles", busy_cnt, 24);
    check("s frame_done", done_seen, 0);
    check("s tready back", pix_s_if.pixel_tready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
